// File: rtl/video_timing_gen_if.sv
// -----------------------------------------------------------------------------
// video_timing_gen_if
//   Bundle between the video timing generator and its consumers (overlay
//   pixel mux / HDMI transmitter).
//   master modport: the generator. It reads the enable and the window
//                   geometry, and drives position, syncs, DE and strobes.
//   slave  modport: the consumer side. It drives the enable and the window
//                   geometry, and reads the timing outputs.
// -----------------------------------------------------------------------------
interface video_timing_gen_if #(
    parameter int hBusWidth = 12,
    parameter int vBusWidth = 12
);
    logic                 countEnable;
    logic [hBusWidth-1:0] windowX;
    logic [hBusWidth-1:0] windowW;
    logic [vBusWidth-1:0] windowY;
    logic [vBusWidth-1:0] windowH;

    logic [hBusWidth-1:0] pixelX;
    logic [vBusWidth-1:0] pixelY;
    logic                 DE;
    logic                 HSYNC;
    logic                 VSYNC;
    logic                 lineStart;
    logic                 frameStart;
    logic                 windowActive;

    modport master (
        input  countEnable, windowX, windowW, windowY, windowH,
        output pixelX, pixelY, DE, HSYNC, VSYNC, lineStart, frameStart, windowActive
    );

    modport slave (
        output countEnable, windowX, windowW, windowY, windowH,
        input  pixelX, pixelY, DE, HSYNC, VSYNC, lineStart, frameStart, windowActive
    );
endinterface

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//   Parametrised raster timing generator. It walks an (h, v) position over
//   hTotal x vTotal clocks and produces registered DE, HSYNC, VSYNC, pixel
//   coordinates, line/frame strobes and an overlay-window flag. The window
//   geometry is shadowed so that it only changes on frame boundaries.
//
//   Ports
//     clock          pixel clock; all logic runs on its rising edge
//     masterReset_n  synchronous reset, active low
//     bus            video_timing_gen_if.master:
//                      in : countEnable, windowX/W/Y/H
//                      out: pixelX, pixelY, DE, HSYNC, VSYNC, lineStart,
//                           frameStart, windowActive
//   Outputs lag the internal counter by one clock.
// -----------------------------------------------------------------------------
module video_timing_gen #(
    parameter int hBusWidth     = 12,
    parameter int vBusWidth     = 12,
    parameter int hActive       = 1920,
    parameter int hFrontPorch   = 88,
    parameter int hSyncWidth    = 44,
    parameter int hBackPorch    = 148,
    parameter int vActive       = 1080,
    parameter int vFrontPorch   = 4,
    parameter int vSyncWidth    = 5,
    parameter int vBackPorch    = 36,
    parameter bit hSyncPolarity = 1'b1,
    parameter bit vSyncPolarity = 1'b1
) (
    input  logic               clock,
    input  logic               masterReset_n,
    video_timing_gen_if.master bus
);

    localparam int H_TOTAL = hActive + hFrontPorch + hSyncWidth + hBackPorch;
    localparam int V_TOTAL = vActive + vFrontPorch + vSyncWidth + vBackPorch;

    if (H_TOTAL > (1 << hBusWidth)) begin : g_h_too_big
        $error("video_timing_gen: hTotal does not fit hBusWidth");
    end
    if (V_TOTAL > (1 << vBusWidth)) begin : g_v_too_big
        $error("video_timing_gen: vTotal does not fit vBusWidth");
    end

    // One extra bit so that boundary constants and window ends never wrap.
    typedef logic [hBusWidth:0] hx_t;
    typedef logic [vBusWidth:0] vx_t;

    localparam hx_t H_ACT_END  = hx_t'(hActive);
    localparam hx_t H_SYNC_BEG = hx_t'(hActive + hFrontPorch);
    localparam hx_t H_SYNC_END = hx_t'(hActive + hFrontPorch + hSyncWidth);
    localparam hx_t H_LAST     = hx_t'(H_TOTAL - 1);
    localparam vx_t V_ACT_END  = vx_t'(vActive);
    localparam vx_t V_SYNC_BEG = vx_t'(vActive + vFrontPorch);
    localparam vx_t V_SYNC_END = vx_t'(vActive + vFrontPorch + vSyncWidth);
    localparam vx_t V_LAST     = vx_t'(V_TOTAL - 1);

    localparam logic [hBusWidth-1:0] H_ONE = {{(hBusWidth-1){1'b0}}, 1'b1};
    localparam logic [vBusWidth-1:0] V_ONE = {{(vBusWidth-1){1'b0}}, 1'b1};

    logic [hBusWidth-1:0] h_count, h_count_next;
    logic [vBusWidth-1:0] v_count, v_count_next;
    logic [hBusWidth-1:0] shadow_x, shadow_w;
    logic [vBusWidth-1:0] shadow_y, shadow_h;

    hx_t  h_ext;
    vx_t  v_ext;
    logic frame_end;
    logic de_d, hsync_on_d, vsync_on_d, window_d;

    assign h_ext     = {1'b0, h_count};
    assign v_ext     = {1'b0, v_count};
    assign frame_end = (h_ext == H_LAST) && (v_ext == V_LAST);

    // Position decode and counter advance for the position currently held.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        h_count_next = h_count + H_ONE;
        v_count_next = v_count;
        if (h_ext == H_LAST) begin
            h_count_next = '0;
            v_count_next = (v_ext == V_LAST) ? '0 : v_count + V_ONE;
        end

        de_d       = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
        hsync_on_d = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
        vsync_on_d = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);
        window_d   = de_d
                   && (h_ext >= {1'b0, shadow_x})
                   && (h_ext <  ({1'b0, shadow_x} + {1'b0, shadow_w}))
                   && (v_ext >= {1'b0, shadow_y})
                   && (v_ext <  ({1'b0, shadow_y} + {1'b0, shadow_h}));
    end

    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values, whatever the statement order.
        if (!masterReset_n) begin
            h_count          <= '0;
            v_count          <= '0;
            // The window is captured during reset too, so the first frame
            // after release already uses the geometry presented in reset.
            shadow_x         <= bus.windowX;
            shadow_w         <= bus.windowW;
            shadow_y         <= bus.windowY;
            shadow_h         <= bus.windowH;
            bus.pixelX       <= '0;
            bus.pixelY       <= '0;
            bus.DE           <= 1'b0;
            bus.HSYNC        <= !hSyncPolarity;
            bus.VSYNC        <= !vSyncPolarity;
            bus.lineStart    <= 1'b0;
            bus.frameStart   <= 1'b0;
            bus.windowActive <= 1'b0;
        end else if (bus.countEnable) begin
            h_count          <= h_count_next;
            v_count          <= v_count_next;
            // Load on the last position of the frame: the position that
            // follows is (0,0), the first one decoded with the new geometry.
            if (frame_end) begin
                shadow_x     <= bus.windowX;
                shadow_w     <= bus.windowW;
                shadow_y     <= bus.windowY;
                shadow_h     <= bus.windowH;
            end
            bus.pixelX       <= h_count;
            bus.pixelY       <= v_count;
            bus.DE           <= de_d;
            bus.HSYNC        <= hsync_on_d ? hSyncPolarity : !hSyncPolarity;
            bus.VSYNC        <= vsync_on_d ? vSyncPolarity : !vSyncPolarity;
            bus.lineStart    <= (h_count == '0);
            bus.frameStart   <= (h_count == '0) && (v_count == '0);
            bus.windowActive <= window_d;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
//   Two generators with the small 8x6 raster, one with active-high syncs and
//   one with active-low syncs, share the same stimulus. Every cycle both are
//   compared with a reference model that derives the position from the count
//   of enabled clocks since reset.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

    localparam int HB    = 12;
    localparam int VB    = 12;
    localparam int H_ACT = 4, H_FP = 1, H_SW = 2, H_BP = 1;
    localparam int V_ACT = 3, V_FP = 1, V_SW = 1, V_BP = 1;
    localparam int H_TOT = H_ACT + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SW + V_BP;
    localparam int FRAME = H_TOT * V_TOT;

    logic          clock = 1'b0;
    logic          masterReset_n;
    logic          ce;
    logic [HB-1:0] wx, ww;
    logic [VB-1:0] wy, wh;

    always #5 clock = ~clock;

    video_timing_gen_if #(.hBusWidth(HB), .vBusWidth(VB)) bus_p ();
    video_timing_gen_if #(.hBusWidth(HB), .vBusWidth(VB)) bus_n ();

    assign bus_p.countEnable = ce;
    assign bus_p.windowX     = wx;
    assign bus_p.windowW     = ww;
    assign bus_p.windowY     = wy;
    assign bus_p.windowH     = wh;
    assign bus_n.countEnable = ce;
    assign bus_n.windowX     = wx;
    assign bus_n.windowW     = ww;
    assign bus_n.windowY     = wy;
    assign bus_n.windowH     = wh;

    video_timing_gen #(
        .hBusWidth(HB), .vBusWidth(VB),
        .hActive(H_ACT), .hFrontPorch(H_FP), .hSyncWidth(H_SW), .hBackPorch(H_BP),
        .vActive(V_ACT), .vFrontPorch(V_FP), .vSyncWidth(V_SW), .vBackPorch(V_BP),
        .hSyncPolarity(1'b1), .vSyncPolarity(1'b1)
    ) dut_p (
        .clock        (clock),
        .masterReset_n(masterReset_n),
        .bus          (bus_p)
    );

    video_timing_gen #(
        .hBusWidth(HB), .vBusWidth(VB),
        .hActive(H_ACT), .hFrontPorch(H_FP), .hSyncWidth(H_SW), .hBackPorch(H_BP),
        .vActive(V_ACT), .vFrontPorch(V_FP), .vSyncWidth(V_SW), .vBackPorch(V_BP),
        .hSyncPolarity(1'b0), .vSyncPolarity(1'b0)
    ) dut_n (
        .clock        (clock),
        .masterReset_n(masterReset_n),
        .bus          (bus_n)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    // Reference model: n = enabled clocks since reset; shadow window.
    int n;
    int sx, sy, sw, sh;
    int e_x, e_y;
    bit e_de, e_hs, e_vs, e_ls, e_fs, e_wa;
    int fs_seen, ls_seen;

    task automatic model_edge(input logic rst_n_v, input logic ce_v);
        int x, y;
        if (!rst_n_v) begin
            n  = 0;
            sx = int'(wx); sy = int'(wy); sw = int'(ww); sh = int'(wh);
            e_x = 0; e_y = 0;
            {e_de, e_hs, e_vs, e_ls, e_fs, e_wa} = '0;
        end else if (ce_v) begin
            x    = n % H_TOT;
            y    = (n / H_TOT) % V_TOT;
            e_x  = x;
            e_y  = y;
            e_de = (x < H_ACT) && (y < V_ACT);
            e_hs = (x >= H_ACT + H_FP) && (x < H_ACT + H_FP + H_SW);
            e_vs = (y >= V_ACT + V_FP) && (y < V_ACT + V_FP + V_SW);
            e_ls = (x == 0);
            e_fs = (x == 0) && (y == 0);
            e_wa = e_de && (x >= sx) && (x < sx + sw) && (y >= sy) && (y < sy + sh);
            if (n % FRAME == FRAME - 1) begin
                sx = int'(wx); sy = int'(wy); sw = int'(ww); sh = int'(wh);
            end
            n++;
        end
    endtask

    task automatic step(input logic rst_n_v, input logic ce_v);
        @(negedge clock);
        masterReset_n = rst_n_v;
        ce            = ce_v;
        @(posedge clock);
        #1;
        model_edge(rst_n_v, ce_v);
        check("pixelX",       32'(bus_p.pixelX),       32'(e_x));
        check("pixelY",       32'(bus_p.pixelY),       32'(e_y));
        check("DE",           32'(bus_p.DE),           32'(e_de));
        check("HSYNC_pos",    32'(bus_p.HSYNC),        32'(e_hs));
        check("VSYNC_pos",    32'(bus_p.VSYNC),        32'(e_vs));
        check("lineStart",    32'(bus_p.lineStart),    32'(e_ls));
        check("frameStart",   32'(bus_p.frameStart),   32'(e_fs));
        check("windowActive", 32'(bus_p.windowActive), 32'(e_wa));
        check("HSYNC_neg",    32'(bus_n.HSYNC),        32'(!e_hs));
        check("VSYNC_neg",    32'(bus_n.VSYNC),        32'(!e_vs));
        check("DE_neg",       32'(bus_n.DE),           32'(e_de));
        fs_seen += int'(bus_p.frameStart);
        ls_seen += int'(bus_p.lineStart);
    endtask

    task automatic set_window(input int x, input int y, input int w, input int h);
        wx = HB'(x); wy = VB'(y); ww = HB'(w); wh = VB'(h);
    endtask

    initial begin
        masterReset_n = 1'b0;
        ce            = 1'b0;
        set_window(1, 1, 2, 1);

        // Reset state, and reset overriding countEnable.
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);

        // Two frames: window (1,1,2,1), then a mid-frame change that only
        // shows up in the second frame.
        fs_seen = 0; ls_seen = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == 20) set_window(0, 0, 4, 3);
            step(1'b1, 1'b1);
        end
        check("frames_in_96", 32'(fs_seen), 32'd2);
        check("lines_in_96",  32'(ls_seen), 32'(2 * V_TOT));

        // Window end beyond the counter range must not wrap.
        set_window(3, 0, 4095, 4095);
        for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 1'b1);

        // Freeze mid-line for 10 clocks, then one frame of enabled clocks.
        for (int i = 0; i < 3; i++)  step(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        fs_seen = 0;
        for (int i = 0; i < FRAME; i++) step(1'b1, 1'b1);
        check("frames_after_pause", 32'(fs_seen), 32'd1);

        // Reset pulse while the counter sits at (2,1).
        for (int i = 0; i < 2 * FRAME && (n % FRAME) != (1 * H_TOT + 2); i++)
            step(1'b1, 1'b1);
        check("reached_2_1", 32'(n % FRAME), 32'(1 * H_TOT + 2));
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("restart_frameStart", 32'(bus_p.frameStart), 32'd1);

        // Randomised enables, window changes and occasional resets.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 3) == 0)
                    set_window(4096 - $urandom_range(1, 3), $urandom_range(0, 5),
                               $urandom_range(0, 4095), 4096 - $urandom_range(1, 3));
                else
                    set_window($urandom_range(0, 7), $urandom_range(0, 5),
                               $urandom_range(0, 5), $urandom_range(0, 4));
            end
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 4) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
